// File: rtl/obi_mem_adapter_pkg.sv
// Shared types and helpers for the OBI-to-SRAM adapter.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
//
// Holds the OBI port configuration struct, a default configuration, and
// default request/response struct types that match that configuration.
package obi_mem_adapter_pkg;

  typedef struct packed {
    int unsigned AddrWidth;
    int unsigned DataWidth;
    int unsigned IdWidth;
    bit          UseRReady;
  } obi_cfg_t;

  localparam int unsigned DefAddrWidth = 32;
  localparam int unsigned DefDataWidth = 32;
  localparam int unsigned DefIdWidth   = 4;

  localparam obi_cfg_t ObiDefaultConfig = '{
    AddrWidth: DefAddrWidth,
    DataWidth: DefDataWidth,
    IdWidth:   DefIdWidth,
    UseRReady: 1'b1
  };

  typedef struct packed {
    logic [DefAddrWidth-1:0]   addr;
    logic                      we;
    logic [DefDataWidth/8-1:0] be;
    logic [DefDataWidth-1:0]   wdata;
    logic [DefIdWidth-1:0]     aid;
  } obi_default_a_chan_t;

  typedef struct packed {
    obi_default_a_chan_t a;
    logic                req;
    logic                rready;
  } obi_default_req_t;

  typedef struct packed {
    logic [DefDataWidth-1:0] rdata;
    logic [DefIdWidth-1:0]   rid;
    logic                    err;
    logic                    r_optional;
  } obi_default_r_chan_t;

  typedef struct packed {
    obi_default_r_chan_t r;
    logic                gnt;
    logic                rvalid;
  } obi_default_rsp_t;

  // Bits needed to hold the values 0..n inclusive.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n + 1) : 1;
  endfunction

  // Bits needed to index n entries.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/obi_mem_adapter_rsp_fifo.sv
// Registered response FIFO for the OBI memory adapter.
// Latency: 1 cycle push-to-visible at head; head is read combinationally.
// Backpressure: push ignored when full, pop ignored when empty; full/empty/usage exported.
//
// Ports: clk_i, rst_ni (sync, active-low), push_i/wdata_i, pop_i/rdata_o,
// full_o, empty_o, usage_o (entries currently stored).
module obi_mem_adapter_rsp_fifo
  import obi_mem_adapter_pkg::*;
#(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4,
  localparam int unsigned UsageW = cnt_width(Depth)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [Width-1:0]  wdata_i,
  input  logic              pop_i,
  output logic [Width-1:0]  rdata_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [UsageW-1:0] usage_o
);

  localparam int unsigned PtrW = idx_width(Depth);

  logic [Width-1:0]  mem_q [Depth];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [UsageW-1:0] usage_q;
  logic              do_push, do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full_o  = (usage_q == UsageW'(Depth));
  assign empty_o = (usage_q == '0);
  assign usage_o = usage_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usage_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (do_push && !do_pop)      usage_q <= usage_q + UsageW'(1);
      else if (!do_push && do_pop) usage_q <= usage_q - UsageW'(1);
    end
  end

  // Storage needs no reset: an entry is only observed after it was pushed.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/obi_mem_adapter.sv
// OBI subordinate endpoint driving a fixed-latency SRAM-style macro.
// Latency: MemLatency+1 cycles from grant to rvalid; one transaction per cycle sustained.
// Backpressure: gnt drops while in-flight plus buffered responses reach NumMaxTrans; rready stalls the R FIFO.
//
// Ports: clk_i, rst_ni (sync, active-low), obi_req_i (A channel + rready),
// obi_rsp_o (gnt + R channel), mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o/mem_be_o
// to the macro, mem_rdata_i valid MemLatency cycles after mem_req_o.
// Optional macro OBI_MEM_ADAPTER_PERF_EN adds perf_clr_i, perf_rd_o, perf_wr_o, perf_err_o.
module obi_mem_adapter
  import obi_mem_adapter_pkg::*;
#(
  parameter obi_cfg_t    ObiCfg       = ObiDefaultConfig,
  parameter type         obi_req_t    = obi_default_req_t,
  parameter type         obi_rsp_t    = obi_default_rsp_t,
  parameter int unsigned MemLatency   = 1,
  parameter int unsigned NumMaxTrans  = 4,
  parameter logic [31:0] MemSizeBytes = 32'h1000
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  obi_req_t                        obi_req_i,
  output obi_rsp_t                        obi_rsp_o,
  output logic                            mem_req_o,
  output logic                            mem_we_o,
  output logic [ObiCfg.AddrWidth-1:0]     mem_addr_o,
  output logic [ObiCfg.DataWidth-1:0]     mem_wdata_o,
  output logic [ObiCfg.DataWidth/8-1:0]   mem_be_o,
  input  logic [ObiCfg.DataWidth-1:0]     mem_rdata_i
`ifdef OBI_MEM_ADAPTER_PERF_EN
  ,
  input  logic                            perf_clr_i,
  output logic [31:0]                     perf_rd_o,
  output logic [31:0]                     perf_wr_o,
  output logic [31:0]                     perf_err_o
`endif
);

  localparam int unsigned DW   = ObiCfg.DataWidth;
  localparam int unsigned IW   = ObiCfg.IdWidth;
  localparam int unsigned CntW = cnt_width(NumMaxTrans);

  typedef struct packed {
    logic [IW-1:0] id;
    logic          we;
    logic          err;
  } mem_adapter_meta_t;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic [IW-1:0] id;
    logic          err;
  } mem_adapter_rsp_t;

  logic                  gnt, hs, in_range, pop;
  logic [CntW-1:0]       cnt_q;
  logic [MemLatency-1:0] pipe_vld_q;
  mem_adapter_meta_t     pipe_meta_q [MemLatency];
  mem_adapter_meta_t     exit_meta;
  logic                  fifo_push, fifo_full, fifo_empty;
  logic [CntW-1:0]       fifo_usage;
  mem_adapter_rsp_t      fifo_wdata, fifo_rdata;

  // Compare at 64 bits so neither side is truncated for any address width.
  assign in_range = 64'(obi_req_i.a.addr) < 64'(MemSizeBytes);

  // Credits cover both in-flight and buffered responses, so a granted request
  // always has a FIFO slot waiting for it.
  assign gnt = (cnt_q < CntW'(NumMaxTrans));
  assign hs  = obi_req_i.req & gnt;

  assign mem_req_o   = hs & in_range;
  assign mem_we_o    = obi_req_i.a.we;
  assign mem_addr_o  = obi_req_i.a.addr;
  assign mem_wdata_o = obi_req_i.a.wdata;
  assign mem_be_o    = obi_req_i.a.be;

  // Metadata travels alongside the macro's read latency.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pipe_vld_q <= '0;
    end else begin
      pipe_vld_q[0] <= hs;
      for (int i = 1; i < MemLatency; i++) pipe_vld_q[i] <= pipe_vld_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    pipe_meta_q[0] <= '{id: obi_req_i.a.aid, we: obi_req_i.a.we, err: !in_range};
    for (int i = 1; i < MemLatency; i++) pipe_meta_q[i] <= pipe_meta_q[i-1];
  end

  assign exit_meta = pipe_meta_q[MemLatency-1];
  assign fifo_push = pipe_vld_q[MemLatency-1];

  // Only in-range reads return macro data; writes and errors return zero.
  always_comb begin
    fifo_wdata       = '0;
    fifo_wdata.id    = exit_meta.id;
    fifo_wdata.err   = exit_meta.err;
    fifo_wdata.rdata = (exit_meta.we || exit_meta.err) ? '0 : mem_rdata_i;
  end

  obi_mem_adapter_rsp_fifo #(
    .Width ($bits(mem_adapter_rsp_t)),
    .Depth (NumMaxTrans)
  ) i_rsp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .usage_o (fifo_usage)
  );

  assign pop = ~fifo_empty & (obi_req_i.rready | !ObiCfg.UseRReady);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (hs && !pop) begin
      cnt_q <= cnt_q + CntW'(1);
    end else if (!hs && pop) begin
      cnt_q <= cnt_q - CntW'(1);
    end
  end

  always_comb begin
    obi_rsp_o              = '0;
    obi_rsp_o.gnt          = gnt;
    obi_rsp_o.rvalid       = ~fifo_empty;
    obi_rsp_o.r.rdata      = fifo_rdata.rdata;
    obi_rsp_o.r.rid        = fifo_rdata.id;
    obi_rsp_o.r.err        = fifo_rdata.err;
    obi_rsp_o.r.r_optional = '0;
  end

  // The credit rule must make these impossible.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(fifo_push && fifo_full));
  a_usage_in_cnt: assert property (@(posedge clk_i) disable iff (!rst_ni)
    fifo_usage <= cnt_q);
  a_cnt_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    cnt_q <= CntW'(NumMaxTrans));

`ifdef OBI_MEM_ADAPTER_PERF_EN
  logic [31:0] perf_rd_q, perf_wr_q, perf_err_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || perf_clr_i) begin
      perf_rd_q  <= '0;
      perf_wr_q  <= '0;
      perf_err_q <= '0;
    end else begin
      if (mem_req_o && !obi_req_i.a.we && (perf_rd_q != '1)) perf_rd_q <= perf_rd_q + 32'd1;
      if (mem_req_o &&  obi_req_i.a.we && (perf_wr_q != '1)) perf_wr_q <= perf_wr_q + 32'd1;
      if (pop && fifo_rdata.err && (perf_err_q != '1))       perf_err_q <= perf_err_q + 32'd1;
    end
  end

  assign perf_rd_o  = perf_rd_q;
  assign perf_wr_o  = perf_wr_q;
  assign perf_err_o = perf_err_q;
`endif

endmodule
